// File: rtl/alu_issue_sched.sv
// Two-port issue scheduler for the shared integer ALU: arbitrates, issues one uop,
// waits for the result under a watchdog and returns a port/tag-stamped response.
// Define ALU_SCHED_RR_EN for round-robin arbitration; default is fixed priority (port 0).
module alu_issue_sched #(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [6:0]       req0_instr_type,
    input  logic [2:0]       req0_funct3,
    input  logic [6:0]       req0_funct7,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [6:0]       req1_instr_type,
    input  logic [2:0]       req1_funct3,
    input  logic [6:0]       req1_funct7,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             alu_uop_valid,
    output logic [6:0]       alu_instr_type,
    output logic [2:0]       alu_funct3,
    output logic [6:0]       alu_funct7,
    input  logic             alu_res_valid,
    input  logic [XLEN-1:0]  alu_res_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_port,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [XLEN-1:0]  rsp_data,
    output logic             rsp_timeout,
    output logic             busy,
    output logic             timeout_err
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          gnt;
    logic          gnt_vld;
    logic          accept;

`ifdef ALU_SCHED_RR_EN
    logic ptr;
    // The pointer only breaks ties; a lone requester always wins.
    assign gnt = (req0_valid && req1_valid) ? ptr : !req0_valid;
`else
    assign gnt = !req0_valid;
`endif

    assign gnt_vld    = req0_valid || req1_valid;
    assign req0_ready = (state == IDLE) && gnt_vld && !gnt && !flush;
    assign req1_ready = (state == IDLE) && gnt_vld &&  gnt && !flush;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            alu_uop_valid  <= 1'b0;
            alu_instr_type <= '0;
            alu_funct3     <= '0;
            alu_funct7     <= '0;
            rsp_valid      <= 1'b0;
            rsp_port       <= 1'b0;
            rsp_tag        <= '0;
            rsp_data       <= '0;
            rsp_timeout    <= 1'b0;
            timeout_err    <= 1'b0;
`ifdef ALU_SCHED_RR_EN
            ptr            <= 1'b0;
`endif
        end else if (flush) begin
            // Abort wins over any handshake; pointer and sticky error survive.
            state         <= IDLE;
            cnt           <= '0;
            alu_uop_valid <= 1'b0;
            rsp_valid     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    alu_instr_type <= gnt ? req1_instr_type : req0_instr_type;
                    alu_funct3     <= gnt ? req1_funct3     : req0_funct3;
                    alu_funct7     <= gnt ? req1_funct7     : req0_funct7;
                    rsp_tag        <= gnt ? req1_tag        : req0_tag;
                    rsp_port       <= gnt;
                    alu_uop_valid  <= 1'b1;
                    state          <= ISSUE;
`ifdef ALU_SCHED_RR_EN
                    ptr            <= !gnt;
`endif
                end
                ISSUE: begin
                    alu_uop_valid <= 1'b0;
                    cnt           <= '0;
                    state         <= WAIT;
                end
                WAIT: begin
                    // A result on the final watchdog cycle takes precedence.
                    if (alu_res_valid) begin
                        rsp_data    <= alu_res_data;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else if (cnt == CNT_MAX) begin
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b1;
                        timeout_err <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_issue_sched.md
# alu_issue_sched

Issue scheduler that shares the single integer ALU (ALU control decode plus adder/logic datapath) between two uop requesters, such as decode slot 0 and slot 1. It accepts one uop at a time over a valid/ready handshake and drives the ALU control inputs for exactly one cycle. It then waits for the ALU result under a watchdog and returns the result, tagged with the originating port, over a valid/ready response channel. It sits between the decode/dispatch stage and the ALU control stage in the execution cluster.

## Interface
Parameters:
- XLEN, 32, result data width
- TAG_W, 4, requester tag width
- TIMEOUT, 16, maximum WAIT cycles before the watchdog fires (≥2)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  synchronous abort of any in-flight uop
- req0_valid / req1_valid  in  1  uop offered by port 0 / port 1
- req0_ready / req1_ready  out  1  uop accepted this cycle when valid&ready
- reqN_instr_type  in  7  opcode class, R-type / I-type (N = 0, 1)
- reqN_funct3  in  3  funct3
- reqN_funct7  in  7  funct7
- reqN_tag  in  TAG_W  requester tag
- alu_uop_valid  out  1  one-cycle issue pulse to ALU control
- alu_instr_type / alu_funct3 / alu_funct7  out  7/3/7  latched uop fields
- alu_res_valid  in  1  ALU result valid
- alu_res_data  in  XLEN  ALU result
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_port  out  1  originating port
- rsp_tag  out  TAG_W  originating tag
- rsp_data  out  XLEN  result; 0 on timeout
- rsp_timeout  out  1  response produced by the watchdog
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky watchdog error

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - The arbiter picks a grant port from req0_valid, req1_valid and the priority pointer.
  - reqN_ready = (state==IDLE) & grant==N & !flush. At most one ready is high.
  - On handshake: latch fields, tag and port; advance the pointer to the other port; go to ISSUE.
- **ISSUE**
  - alu_uop_valid=1 with the latched fields.
  - Clear the watchdog counter (width $clog2(TIMEOUT)).
  - Go to WAIT.
- **WAIT**
  - The counter increments each cycle.
  - On alu_res_valid: latch alu_res_data, set rsp_timeout=0, go to RESP.
  - Else, when counter==TIMEOUT-1: set rsp_data=0, rsp_timeout=1 and timeout_err=1; go to RESP.
  - A result arriving in the same cycle as the timeout wins; no error is flagged.
- **RESP**
  - rsp_valid=1; rsp_port, rsp_tag, rsp_data and rsp_timeout stay stable until rsp_ready.
  - On handshake: go to IDLE.
- alu_res_valid outside WAIT is ignored.
- alu_uop_valid is never high outside ISSUE.
- **flush:** from any state, go to IDLE next cycle.
  - rsp_valid and alu_uop_valid drop, and the counter clears.
  - The priority pointer and timeout_err are unchanged.
  - flush has priority over every handshake in the same cycle.
- alu_* field outputs hold their last issued value between issues.

## Timing
- Reset values:
  - state IDLE, pointer=port 0.
  - All outputs 0, including req*_ready, alu_* outputs, rsp_* outputs, busy and timeout_err.
  - timeout_err clears only on reset.
- Cycle sequence, with accept at cycle T:
  - T+1: alu_uop_valid.
  - T+2: WAIT starts. The ALU control stage is registered, so the earliest result is at T+3.
  - Result sampled at cycle R: rsp_valid at R+1.
- Minimum accept-to-response latency is 4 cycles. Maximum is TIMEOUT+2 cycles plus rsp_ready stall.
- Throughput is one uop per ≥5 cycles. The next accept is possible in the cycle after the RESP handshake.
- busy asserts the cycle after accept and deasserts the cycle after the RESP handshake or flush.

## Configuration
- ALU_SCHED_RR_EN defined: round-robin arbitration. If both ports are valid, the pointer port wins; a single valid port always wins.
- ALU_SCHED_RR_EN undefined: fixed priority, port 0 always wins when valid. The pointer is not implemented.

## Test plan
- Single uop: req0 ADD tag=3; ALU returns 0x0000_0005 at T+3. Expect alu_uop_valid only at T+1, rsp_valid at T+4 with port=0, tag=3, data=5, rsp_timeout=0.
- Contention with RR enabled: both ports valid continuously with tags 1 and 2. Expect the grant order 0,1,0,1, with each port's ready high only in its granted IDLE cycle. With RR disabled, expect port 0 only.
- Backpressure: hold rsp_ready=0 for 6 cycles in RESP. Expect rsp fields stable, both req*_ready=0, and no second alu_uop_valid.
- Watchdog: no alu_res_valid after issue. Expect rsp_valid with data=0, rsp_timeout=1, timeout_err=1 after TIMEOUT WAIT cycles, with timeout_err still 1 after the next successful uop.
- Result on the last WAIT cycle: alu_res_valid exactly at counter==TIMEOUT-1 with data 0xA. Expect data=0xA, rsp_timeout=0, timeout_err=0.
- Flush: pulse flush during WAIT, then during RESP, then in the same cycle as req0_valid in IDLE. Expect IDLE next cycle, rsp_valid=0, no accept in the flush cycle, and a late alu_res_valid ignored.
